// File: rtl/adc_capture_avmm_writer.sv
// -----------------------------------------------------------------------------
// adc_capture_avmm_writer
//
// Avalon-MM write master feeding the capture-RAM slave bridge. After an arm
// pulse it waits for a trigger, then takes cfg_length sample words from an
// unthrottled ADC stream. Each word is written to consecutive RAM addresses
// starting at cfg_base (wrapping modulo 2^AW). A small FIFO absorbs
// waitrequest stalls. Samples that arrive while the FIFO is full are dropped.
// Dropped samples still count towards the length, and they set the sticky
// overflow flag.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   arm, abort          one-cycle control pulses
//   trigger             level; starts the capture while armed
//   cfg_base/length     first word address / number of words (0..2^AW)
//   s_valid, s_data     sample stream, no backpressure
//   m_*                 Avalon-MM master (write only; m_read tied 0)
//   busy, done          status (busy also covers the abort flush)
//   overflow            sticky: at least one sample was dropped
//   words_written       writes accepted in the current capture
// -----------------------------------------------------------------------------
module adc_capture_avmm_writer #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          abort,
  input  logic          trigger,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW:0]   cfg_length,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic [AW-1:0] m_address,
  output logic          m_write,
  output logic [DW-1:0] m_writedata,
  output logic          m_read,
  input  logic          m_waitrequest,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   words_written
);

  localparam int PW = $clog2(FD);
  localparam int CW = PW + 1;

  // S_ABORT holds a stalled write until it is accepted, then flushes the FIFO.
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE, S_ABORT
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] mem_q [FD];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   accepted_q, accepted_d;
  logic [AW:0]   dropped_q, dropped_d;
  logic [AW:0]   written_q, written_d;
  logic          overflow_q, overflow_d;

  logic fifo_empty, fifo_full, pop, take, push, drop;
  logic arm_fire, abort_fire, in_window, flush;

  // ---------------------------------------------------------------------------
  // Control strobes
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FD));
  assign pop        = ~fifo_empty & ~m_waitrequest;
  assign abort_fire = abort & ((state_q == S_ARMED) | (state_q == S_CAPTURE));
  assign arm_fire   = arm & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));

  // Samples are taken from the trigger cycle onward, until the length is met.
  assign in_window = ((state_q == S_CAPTURE) | ((state_q == S_ARMED) & trigger))
                     & ~abort_fire & (accepted_q < len_q);
  assign take = s_valid & in_window;
  // A full FIFO still accepts a push when the head pops in the same cycle.
  assign push = take & (~fifo_full | pop);
  assign drop = take & ~push;

  // The FIFO is flushed when an abort finds no stalled write. It is also
  // flushed once the stalled write that was held through the abort completes.
  assign flush = (abort_fire & ~(~fifo_empty & m_waitrequest))
               | ((state_q == S_ABORT) & (pop | fifo_empty));

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the branches; a path that
    // leaves one unassigned would infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    base_d     = base_q;
    len_d      = len_q;
    accepted_d = accepted_q + (AW+1)'(take);
    dropped_d  = dropped_q + (AW+1)'(drop);
    written_d  = written_q + (AW+1)'(pop);
    overflow_d = overflow_q | drop;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (arm_fire) begin
      base_d     = cfg_base;
      len_d      = cfg_length;
      accepted_d = '0;
      dropped_d  = '0;
      written_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      base_q     <= '0;
      len_q      <= '0;
      accepted_q <= '0;
      dropped_q  <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      base_q     <= base_d;
      len_q      <= len_d;
      accepted_q <= accepted_d;
      dropped_q  <= dropped_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the FIFO storage has no reset; validity is tracked by count_q, and
  // the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_fire) state_d = (cfg_length == '0) ? S_DONE : S_ARMED;
      end
      S_ARMED: begin
        if (abort_fire)   state_d = flush ? S_IDLE : S_ABORT;
        else if (trigger) state_d = (accepted_d == len_q) ? S_DRAIN : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort_fire)                 state_d = flush ? S_IDLE : S_ABORT;
        else if (accepted_d == len_q)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((count_d == '0) && ((written_d + dropped_d) == len_q)) state_d = S_DONE;
      end
      S_ABORT: begin
        if (flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == S_ARMED) | (state_q == S_CAPTURE)
                  | (state_q == S_DRAIN) | (state_q == S_ABORT);
    done          = (state_q == S_DONE);
    m_write       = ~fifo_empty;
    m_writedata   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    m_address     = base_q + written_q[AW-1:0];
    m_read        = 1'b0;
    overflow      = overflow_q;
    words_written = written_q;
  end

endmodule

// File: tb/tb_adc_capture_avmm_writer.sv
// -----------------------------------------------------------------------------
// Directed testbench for adc_capture_avmm_writer (AW=12, DW=32, FD=4).
// Inputs change 1 ns after each rising edge. A negedge monitor logs every
// accepted Avalon write. The expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_adc_capture_avmm_writer;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm, abort, trigger;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_length;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [AW-1:0] m_address;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_read;
  logic          m_waitrequest;
  logic          busy, done, overflow;
  logic [AW:0]   words_written;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];

  logic [AW-1:0] wrap_addr [4];

  adc_capture_avmm_writer #(.AW(AW), .DW(DW), .FD(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .abort         (abort),
    .trigger       (trigger),
    .cfg_base      (cfg_base),
    .cfg_length    (cfg_length),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_read        (m_read),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && m_write && !m_waitrequest) begin
      log_addr.push_back(m_address);
      log_data.push_back(m_writedata);
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    cfg_base = '0; cfg_length = '0; s_valid = 1'b0; s_data = '0;
    m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_m_address", 64'(m_address), 64'd0);
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_m_writedata", 64'(m_writedata), 64'd0);
    check("rst_m_read", 64'(m_read), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_words_written", 64'(words_written), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Basic capture: base 0x010, length 4, no stalls
    clear_log();
    cfg_base = 12'h010; cfg_length = 13'd4; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("basic_armed_busy", 64'(busy), 64'd1);
    check("basic_armed_done", 64'(done), 64'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      tick();
      if (i == 1) begin
        check("basic_latency_m_write", 64'(m_write), 64'd1);
        check("basic_latency_addr", 64'(m_address), 64'h010);
        check("basic_latency_data", 64'(m_writedata), 64'd1);
      end
    end
    s_valid = 1'b0;
    check("basic_not_done_early", 64'(done), 64'd0);
    tick();
    check("basic_done", 64'(done), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_words", 64'(words_written), 64'd4);
    check("basic_overflow", 64'(overflow), 64'd0);
    check("basic_m_write_idle", 64'(m_write), 64'd0);
    check("basic_nwrites", 64'(log_addr.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_addr%0d", k), 64'(log_addr[k]), 64'h010 + 64'(k));
      check($sformatf("basic_data%0d", k), 64'(log_data[k]), 64'(k + 1));
    end
    check("basic_back_to_back", 64'(log_cyc[3] - log_cyc[0]), 64'd3);

    // Address wrap. The sample arrives in the trigger cycle, and a late
    // sample is sent while draining.
    clear_log();
    cfg_base = 12'hFFE; cfg_length = 13'd4; arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1; s_valid = 1'b1; s_data = 32'hA0;
    tick();
    trigger = 1'b0;
    check("wrap_first_m_write", 64'(m_write), 64'd1);
    check("wrap_first_data", 64'(m_writedata), 64'hA0);
    check("wrap_first_addr", 64'(m_address), 64'hFFE);
    for (int i = 1; i <= 3; i++) begin
      s_data = 32'hA0 + 32'(i);
      tick();
    end
    s_data = 32'hBAD;
    tick();
    s_valid = 1'b0;
    check("wrap_done", 64'(done), 64'd1);
    check("wrap_nwrites", 64'(log_addr.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_addr%0d", k), 64'(log_addr[k]), 64'(wrap_addr[k]));
      check($sformatf("wrap_data%0d", k), 64'(log_data[k]), 64'hA0 + 64'(k));
    end

    // Stall: waitrequest high for 3 clk at the second write
    clear_log();
    cfg_base = 12'h100; cfg_length = 13'd6; arm = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1; s_data = 32'h10 + 32'(i);
      m_waitrequest = (i >= 3 && i <= 5);
      tick();
      if (i >= 3 && i <= 5) begin
        check($sformatf("stall_hold_addr_c%0d", i), 64'(m_address), 64'h101);
        check($sformatf("stall_hold_data_c%0d", i), 64'(m_writedata), 64'h12);
        check($sformatf("stall_hold_write_c%0d", i), 64'(m_write), 64'd1);
      end
    end
    s_valid = 1'b0; m_waitrequest = 1'b0;
    wait_done("stall_done", 20);
    check("stall_overflow", 64'(overflow), 64'd0);
    check("stall_words", 64'(words_written), 64'd6);
    check("stall_nwrites", 64'(log_addr.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("stall_addr%0d", k), 64'(log_addr[k]), 64'h100 + 64'(k));
      check($sformatf("stall_data%0d", k), 64'(log_data[k]), 64'h11 + 64'(k));
    end

    // Overflow: one write gets through, then waitrequest stays high for 10 clk
    clear_log();
    cfg_base = 12'h200; cfg_length = 13'd8; arm = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      s_valid = (n <= 8); s_data = 32'h20 + 32'(n);
      m_waitrequest = (n >= 3);
      tick();
    end
    s_valid = 1'b0; m_waitrequest = 1'b0;
    check("ovf_flag_during_stall", 64'(overflow), 64'd1);
    wait_done("ovf_done", 20);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_words", 64'(words_written), 64'd5);
    check("ovf_nwrites", 64'(log_addr.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ovf_addr%0d", k), 64'(log_addr[k]), 64'h200 + 64'(k));
      check($sformatf("ovf_data%0d", k), 64'(log_data[k]), 64'h21 + 64'(k));
    end

    // Abort while a write is stalled
    clear_log();
    cfg_base = 12'h300; cfg_length = 13'd8; arm = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    s_valid = 1'b1; s_data = 32'h31;
    tick();
    s_data = 32'h32; m_waitrequest = 1'b1;
    tick();
    check("abort_pending_write", 64'(m_write), 64'd1);
    s_data = 32'h33; abort = 1'b1;
    tick();
    abort = 1'b0;
    s_data = 32'h34; arm = 1'b1; cfg_length = 13'd0;
    tick();
    arm = 1'b0;
    check("abort_hold_write", 64'(m_write), 64'd1);
    check("abort_hold_addr", 64'(m_address), 64'h300);
    check("abort_hold_data", 64'(m_writedata), 64'h31);
    check("abort_hold_done", 64'(done), 64'd0);
    s_valid = 1'b0; m_waitrequest = 1'b0;
    tick();
    check("abort_flushed_write", 64'(m_write), 64'd0);
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_done", 64'(done), 64'd0);
    check("abort_words", 64'(words_written), 64'd1);
    tick();
    check("abort_stays_idle", 64'(busy), 64'd0);
    check("abort_nwrites", 64'(log_addr.size()), 64'd1);
    check("abort_data0", 64'(log_data[0]), 64'h31);

    // Zero length: done on the next clock, words_written cleared, no writes
    clear_log();
    cfg_base = 12'h050; cfg_length = 13'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_words", 64'(words_written), 64'd0);
    tick();
    check("len0_m_write", 64'(m_write), 64'd0);
    check("len0_nwrites", 64'(log_addr.size()), 64'd0);

    // Asynchronous reset in the middle of a capture
    cfg_base = 12'h400; cfg_length = 13'd4; arm = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    s_valid = 1'b1; s_data = 32'h41;
    tick();
    s_data = 32'h42;
    tick();
    check("midrst_pre_words", 64'(words_written), 64'd1);
    check("midrst_pre_addr", 64'(m_address), 64'h401);
    #2;
    reset_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_m_address", 64'(m_address), 64'd0);
    check("midrst_m_write", 64'(m_write), 64'd0);
    check("midrst_m_writedata", 64'(m_writedata), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_words", 64'(words_written), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("midrst_after_busy", 64'(busy), 64'd0);
    check("midrst_after_m_write", 64'(m_write), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
